// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The master side launches operations; the slave side reports busy and HI/LO.
interface mdu_unit_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdu_op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdu_op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit: computes the result at accept, holds it in temp regs,
// and commits it to HI/LO after a fixed busy latency. Also handles MTHI/MTLO.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     temp_hi_q, temp_lo_q;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, den_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_by_zero;
  logic [31:0] res_hi, res_lo;

  // 64x64 product of the sign-extended operands keeps the correct low 64 bits.
  assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign div_by_zero = (bus.b == 32'd0);
  assign a_mag       = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign b_mag       = bus.b[31] ? (32'd0 - bus.b) : bus.b;
  assign den_s       = div_by_zero ? 32'd1 : b_mag;
  assign den_u       = div_by_zero ? 32'd1 : bus.b;
  assign q_mag       = a_mag / den_s;
  assign r_mag       = a_mag % den_s;
  assign q_s         = (bus.a[31] ^ bus.b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s         = bus.a[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u         = bus.a / den_u;
  assign r_u         = bus.a % den_u;

  // Divide by zero reloads the current HI/LO so the commit is a no-op.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (bus.mdu_op)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        if (!div_by_zero) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      OpDivu: begin
        if (!div_by_zero) begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi_q <= '0;
      temp_lo_q <= '0;
    end else if (busy_q) begin
      if (cnt_q == CntW'(1)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
        hi_q   <= temp_hi_q;
        lo_q   <= temp_lo_q;
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end else if (bus.start) begin
      case (bus.mdu_op)
        OpMult, OpMultu: begin
          temp_hi_q <= res_hi;
          temp_lo_q <= res_lo;
          cnt_q     <= CntW'(MULT_CYCLES);
          busy_q    <= 1'b1;
        end
        OpDiv, OpDivu: begin
          temp_hi_q <= res_hi;
          temp_lo_q <= res_lo;
          cnt_q     <= CntW'(DIV_CYCLES);
          busy_q    <= 1'b1;
        end
        OpMthi:  hi_q <= bus.a;
        OpMtlo:  lo_q <= bus.a;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
